alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_exec_unit_if.sv | 25 ++
 rtl/seq_multiplier.sv | 52 +++++
 rtl/alu_exec_unit.sv | 124 ++++++++++++
 tb/tb_alu_exec_unit.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution unit: opcodes, flag layout,
// FSM states and multiplier sizing.
package alu_pkg;

  localparam int DATA_W    = 32;
  localparam int SHAMT_W   = 5;
  localparam int MUL_ITERS = 32;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic              c;
    logic              v;
  } alu_out_t;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between an issuing stage and alu_exec_unit.
interface alu_exec_unit_if;
  import alu_pkg::*;

  logic              Start;
  logic [2:0]        ALUControl;
  logic [1:0]        FlagWrite;
  logic [DATA_W-1:0] SrcA;
  logic [DATA_W-1:0] SrcB;
  logic [DATA_W-1:0] ALUResult;
  logic [3:0]        ALUFlags;
  logic              Busy;
  logic              Done;

  modport master (
    output Start, ALUControl, FlagWrite, SrcA, SrcB,
    input  ALUResult, ALUFlags, Busy, Done
  );

  modport slave (
    input  Start, ALUControl, FlagWrite, SrcA, SrcB,
    output ALUResult, ALUFlags, Busy, Done
  );

endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, one partial-product step per cycle,
// returning the low DATA_W bits of the unsigned product.
module seq_multiplier
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam logic [4:0] LAST_ITER = 5'(MUL_ITERS - 1);

  logic              run;
  logic [4:0]        cnt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc_nxt;

  // The final step is handed out combinationally so the owner can register
  // it on the same edge that ends the iteration sequence.
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
  assign done    = run && (cnt == LAST_ITER);
  assign product = acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run    <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      run    <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (run) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 5'd1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle add/sub/shift/xor, iterative multiply,
// with per-field flag write enables and a one-cycle Done pulse.
module alu_exec_unit
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  alu_exec_unit_if.slave bus
);

  state_t            state_q, state_d;
  logic              accept;
  logic              is_mul_req;
  logic              mul_start;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;
  logic [DATA_W-1:0] result_q;
  logic [3:0]        flags_q;
  logic [1:0]        fw_q;
  alu_out_t          single;

  function automatic alu_out_t alu_single(input logic [2:0]        op,
                                          input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b);
    alu_out_t          o;
    logic [DATA_W:0]   sum;
    o   = '0;
    sum = '0;
    case (op)
      OP_ADD: begin
        sum   = {1'b0, a} + {1'b0, b};
        o.res = sum[DATA_W-1:0];
        o.c   = sum[DATA_W];
        o.v   = (a[DATA_W-1] == b[DATA_W-1]) && (o.res[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        sum   = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
        o.res = sum[DATA_W-1:0];
        o.c   = sum[DATA_W];
        o.v   = (a[DATA_W-1] != b[DATA_W-1]) && (o.res[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SLL:  o.res = a << b[SHAMT_W-1:0];
      OP_SRL:  o.res = a >> b[SHAMT_W-1:0];
      OP_XOR:  o.res = a ^ b;
      // Reserved codes (and mul, which never takes this path) yield zero.
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic logic [3:0] merge_flags(input logic [3:0]        old,
                                             input logic [DATA_W-1:0] res,
                                             input logic              c,
                                             input logic              v,
                                             input logic [1:0]        fw);
    logic [3:0] f;
    f = old;
    if (fw[1]) begin
      f[FLAG_N] = res[DATA_W-1];
      f[FLAG_Z] = (res == '0);
    end
    if (fw[0]) begin
      f[FLAG_C] = c;
      f[FLAG_V] = v;
    end
    return f;
  endfunction

  assign accept     = bus.Start && (state_q != ST_MUL);
  assign is_mul_req = (bus.ALUControl == OP_MUL);
  assign mul_start  = accept && is_mul_req;
  assign single     = alu_single(bus.ALUControl, bus.SrcA, bus.SrcB);

  seq_multiplier u_mul (
    .clk     (clk),
    .rst_n   (reset),
    .start   (mul_start),
    .a       (bus.SrcA),
    .b       (bus.SrcB),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) state_d = is_mul_req ? ST_MUL : ST_DONE;
        else        state_d = ST_IDLE;
      end
      ST_MUL:  if (mul_done) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Completion stage: result/flags register on entry to DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flags_q  <= '0;
      fw_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (is_mul_req) begin
          fw_q <= bus.FlagWrite;
        end else begin
          result_q <= single.res;
          flags_q  <= merge_flags(flags_q, single.res, single.c, single.v, bus.FlagWrite);
        end
      end else if ((state_q == ST_MUL) && mul_done) begin
        result_q <= mul_product;
        flags_q  <= merge_flags(flags_q, mul_product, 1'b0, 1'b0, fw_q);
      end
    end
  end

  assign bus.ALUResult = result_q;
  assign bus.ALUFlags  = flags_q;
  assign bus.Busy      = (state_q != ST_IDLE);
  assign bus.Done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized self-checking bench for alu_exec_unit with an arithmetic
// reference model and directed corner cases.
module tb_alu_exec_unit;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [3:0] mdl_flags;

  localparam longint SMAX = 64'sh7FFFFFFF;
  localparam longint SMIN = -64'sh80000000;

  alu_exec_unit_if bus ();

  alu_exec_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {flags, result} from plain arithmetic on the operation's meaning.
  function automatic logic [35:0] model(input logic [2:0] op, input logic [1:0] fw,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] fl);
    logic [63:0] wide;
    longint      sa, sb, sr;
    logic [31:0] r;
    logic        c, v;
    logic [3:0]  nf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0; v = 1'b0; r = 32'd0;
    case (op)
      3'b000: begin
        wide = {32'd0, a} + {32'd0, b};
        r = wide[31:0]; c = wide[32];
        sr = sa + sb; v = (sr > SMAX) || (sr < SMIN);
      end
      3'b001: begin
        r = a - b; c = (a >= b);
        sr = sa - sb; v = (sr > SMAX) || (sr < SMIN);
      end
      3'b010: begin
        wide = {32'd0, a} * {32'd0, b};
        r = wide[31:0];
      end
      3'b011: r = a << b[4:0];
      3'b111: r = a >> b[4:0];
      3'b101: r = a ^ b;
      default: r = 32'd0;
    endcase
    nf = fl;
    if (fw[1]) begin nf[3] = r[31]; nf[2] = (r == 32'd0); end
    if (fw[0]) begin nf[1] = c; nf[0] = v; end
    return {nf, r};
  endfunction

  task automatic scramble();
    bus.ALUControl = 3'($urandom_range(0, 7));
    bus.FlagWrite  = 2'($urandom_range(0, 3));
    bus.SrcA       = $urandom;
    bus.SrcB       = $urandom;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [1:0] fw,
                        input logic [31:0] a, input logic [31:0] b,
                        input bit inject, input string tag);
    logic [35:0] e;
    int cyc, busy_cnt;
    e = model(op, fw, a, b, mdl_flags);
    @(negedge clk);
    bus.Start = 1'b1; bus.ALUControl = op; bus.FlagWrite = fw;
    bus.SrcA = a; bus.SrcB = b;
    @(negedge clk);
    bus.Start = 1'b0;
    scramble();
    cyc = 1;
    busy_cnt = 0;
    if (op == 3'b010) begin
      while (!bus.Done && cyc < 40) begin
        busy_cnt += int'(bus.Busy);
        if (inject && cyc == 10) begin
          bus.Start = 1'b1; bus.ALUControl = 3'b000; bus.FlagWrite = 2'b11;
        end else begin
          bus.Start = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
      bus.Start = 1'b0;
      busy_cnt += int'(bus.Busy);
      check_eq({tag, "_latency"}, 64'(cyc), 64'd33);
      check_eq({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
    end
    check_eq({tag, "_done"}, 64'(bus.Done), 64'd1);
    check_eq({tag, "_busy_done"}, 64'(bus.Busy), 64'd1);
    check_eq({tag, "_result"}, 64'(bus.ALUResult), 64'(e[31:0]));
    check_eq({tag, "_flags"}, 64'(bus.ALUFlags), 64'(e[35:32]));
    mdl_flags = e[35:32];
    @(negedge clk);
    check_eq({tag, "_done_clr"}, 64'(bus.Done), 64'd0);
    check_eq({tag, "_idle"}, 64'(bus.Busy), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return 32'hFFFFFFFF;
      1: return 32'h80000000;
      2: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [35:0] e1, e2;
    int cyc, done_seen;

    reset = 1'b0;
    bus.Start = 1'b0; bus.ALUControl = 3'd0; bus.FlagWrite = 2'd0;
    bus.SrcA = 32'd0; bus.SrcB = 32'd0;
    mdl_flags = 4'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_result", 64'(bus.ALUResult), 64'd0);
    check_eq("rst_flags", 64'(bus.ALUFlags), 64'd0);
    check_eq("rst_busy", 64'(bus.Busy), 64'd0);
    check_eq("rst_done", 64'(bus.Done), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("post_rst_done", 64'(bus.Done), 64'd0);

    run_op(3'b000, 2'b11, 32'hFFFFFFFF, 32'h1, 1'b0, "add_wrap");
    check_eq("add_wrap_const", 64'({bus.ALUResult, bus.ALUFlags}), 64'({32'h0, 4'b0110}));
    run_op(3'b001, 2'b11, 32'h80000000, 32'h1, 1'b0, "sub_ovf");
    check_eq("sub_ovf_const", 64'({bus.ALUResult, bus.ALUFlags}), 64'({32'h7FFFFFFF, 4'b0011}));
    run_op(3'b101, 2'b10, 32'h5A5A5A5A, 32'h5A5A5A5A, 1'b0, "xor_hold");
    check_eq("xor_hold_const", 64'(bus.ALUFlags), 64'(4'b0111));
    run_op(3'b010, 2'b11, 32'h00010003, 32'h00020005, 1'b1, "mul_dir");
    check_eq("mul_dir_const", 64'(bus.ALUResult), 64'h000B000F);

    // Back-to-back: a second Start held through the DONE cycle.
    e1 = model(3'b011, 2'b11, 32'h1, 32'd31, mdl_flags);
    e2 = model(3'b111, 2'b11, 32'h80000000, 32'd31, e1[35:32]);
    @(negedge clk);
    bus.Start = 1'b1; bus.ALUControl = 3'b011; bus.FlagWrite = 2'b11;
    bus.SrcA = 32'h1; bus.SrcB = 32'd31;
    @(negedge clk);
    check_eq("b2b_first_done", 64'(bus.Done), 64'd1);
    check_eq("b2b_first_result", 64'(bus.ALUResult), 64'(e1[31:0]));
    bus.ALUControl = 3'b111; bus.SrcA = 32'h80000000; bus.SrcB = 32'd31;
    @(negedge clk);
    bus.Start = 1'b0;
    check_eq("b2b_second_done", 64'(bus.Done), 64'd1);
    check_eq("b2b_second_result", 64'(bus.ALUResult), 64'(e2[31:0]));
    check_eq("b2b_second_flags", 64'(bus.ALUFlags), 64'(e2[35:32]));
    mdl_flags = e2[35:32];
    @(negedge clk);
    check_eq("b2b_done_clr", 64'(bus.Done), 64'd0);

    // Reset asserted in the middle of a multiply.
    @(negedge clk);
    bus.Start = 1'b1; bus.ALUControl = 3'b010; bus.FlagWrite = 2'b11;
    bus.SrcA = 32'h1234; bus.SrcB = 32'h5678;
    @(negedge clk);
    bus.Start = 1'b0;
    cyc = 1;
    while (cyc < 15) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("midmul_busy", 64'(bus.Busy), 64'd1);
    reset = 1'b0;
    #1;
    check_eq("midrst_result", 64'(bus.ALUResult), 64'd0);
    check_eq("midrst_flags", 64'(bus.ALUFlags), 64'd0);
    check_eq("midrst_busy", 64'(bus.Busy), 64'd0);
    check_eq("midrst_done", 64'(bus.Done), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    mdl_flags = 4'd0;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      done_seen += int'(bus.Done);
    end
    check_eq("no_stale_done", 64'(done_seen), 64'd0);
    run_op(3'b000, 2'b11, 32'd7, 32'd9, 1'b0, "after_rst");

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), pick(), pick(),
             1'($urandom_range(0, 1)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
